// File: rtl/accel_launcher.sv
// accel_launcher: runs a host-requested batch of accelerator jobs back to back.
// It pulses accel_start for each run and times each run from start to finish.
// A run that exceeds TIMEOUT_CYCLES aborts the batch. Consecutive runs are
// separated by GAP_CYCLES quiet cycles. Per-batch statistics are kept for the host.
module accel_launcher #(
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter int unsigned GAP_CYCLES     = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_go,
  input  logic [7:0]  cmd_runs,
  output logic        busy,
  output logic        done,
  output logic        timeout_err,
  output logic        accel_start,
  input  logic        accel_finish,
  input  logic [31:0] accel_return_val,
  output logic [31:0] last_return_val,
  output logic [31:0] last_cycles,
  output logic [31:0] total_cycles,
  output logic [7:0]  runs_done
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_GAP   = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;
  localparam logic [2:0] S_ERR   = 3'd5;

  localparam logic [31:0] C_TIMEOUT = 32'(TIMEOUT_CYCLES);
  localparam logic [31:0] C_GAP     = 32'(GAP_CYCLES);

  logic [2:0]  r_state;
  logic [2:0]  w_state_next;
  logic [7:0]  r_runs;
  logic [7:0]  r_runs_done;
  logic [31:0] r_cnt;
  logic [31:0] r_gap_cnt;
  logic [31:0] r_last_cycles;
  logic [31:0] r_last_ret;
  logic [31:0] r_total;
  logic        r_timeout_err;

  logic [31:0] w_cnt_inc;
  logic [32:0] w_total_sum;
  logic [31:0] w_total_sat;
  logic [7:0]  w_runs_done_inc;
  logic        w_last_run;
  logic        w_timed_out;
  logic        w_gap_over;

  // Latency of the current run if it finishes this cycle (first WAIT cycle counts as 1).
  assign w_cnt_inc       = r_cnt + 32'd1;
  // 33-bit sum so the carry out can drive saturation.
  assign w_total_sum     = {1'b0, r_total} + {1'b0, w_cnt_inc};
  assign w_total_sat     = w_total_sum[32] ? 32'hFFFF_FFFF : w_total_sum[31:0];
  assign w_runs_done_inc = r_runs_done + 8'd1;
  assign w_last_run      = (w_runs_done_inc == r_runs);
  assign w_timed_out     = (w_cnt_inc >= C_TIMEOUT);
  // The gap only counts quiet cycles, so a stretched finish cannot shorten it.
  assign w_gap_over      = ((r_gap_cnt + 32'd1) >= C_GAP);

  // Next-state logic for the batch sequencer.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (cmd_go) begin
          w_state_next = (cmd_runs == 8'd0) ? S_DONE : S_START;
        end
      end
      S_START: w_state_next = S_WAIT;
      S_WAIT: begin
        if (accel_finish) begin
          w_state_next = w_last_run ? S_DONE : S_GAP;
        end else if (w_timed_out) begin
          w_state_next = S_ERR;
        end
      end
      S_GAP: begin
        if (!accel_finish && w_gap_over) begin
          w_state_next = S_START;
        end
      end
      S_DONE:  w_state_next = S_IDLE;
      S_ERR:   w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Run counters, captured results and batch statistics.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_runs        <= 8'd0;
      r_runs_done   <= 8'd0;
      r_cnt         <= 32'd0;
      r_gap_cnt     <= 32'd0;
      r_last_cycles <= 32'd0;
      r_last_ret    <= 32'd0;
      r_total       <= 32'd0;
      r_timeout_err <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (cmd_go) begin
            r_runs        <= cmd_runs;
            r_runs_done   <= 8'd0;
            r_total       <= 32'd0;
            r_timeout_err <= 1'b0;
          end
        end
        S_START: begin
          r_cnt <= 32'd0;
        end
        S_WAIT: begin
          if (accel_finish) begin
            r_last_cycles <= w_cnt_inc;
            r_last_ret    <= accel_return_val;
            r_total       <= w_total_sat;
            r_runs_done   <= w_runs_done_inc;
            r_gap_cnt     <= 32'd0;
          end else begin
            r_cnt <= w_cnt_inc;
            // Raised on the way into ERR so it is visible alongside done.
            if (w_timed_out) begin
              r_timeout_err <= 1'b1;
            end
          end
        end
        S_GAP: begin
          if (!accel_finish) begin
            r_gap_cnt <= r_gap_cnt + 32'd1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign busy            = (r_state == S_START) || (r_state == S_WAIT) || (r_state == S_GAP);
  assign done            = (r_state == S_DONE) || (r_state == S_ERR);
  assign accel_start     = (r_state == S_START);
  assign timeout_err     = r_timeout_err;
  assign last_return_val = r_last_ret;
  assign last_cycles     = r_last_cycles;
  assign total_cycles    = r_total;
  assign runs_done       = r_runs_done;

endmodule

// File: tb/tb_accel_launcher.sv
// Bench for accel_launcher. It includes a behavioural accelerator and batch
// scoreboard. The expected outcome of each batch is derived from its per-run
// plan and compared when the DUT pulses done.
module tb_accel_launcher;

  localparam int TO  = 16;
  localparam int GAP = 2;

  logic        clk;
  logic        reset;
  logic        cmd_go;
  logic [7:0]  cmd_runs;
  logic        busy;
  logic        done;
  logic        timeout_err;
  logic        accel_start;
  logic        accel_finish;
  logic [31:0] accel_return_val;
  logic [31:0] last_return_val;
  logic [31:0] last_cycles;
  logic [31:0] total_cycles;
  logic [7:0]  runs_done;

  accel_launcher #(.TIMEOUT_CYCLES(TO), .GAP_CYCLES(GAP)) dut (
    .clk(clk), .reset(reset), .cmd_go(cmd_go), .cmd_runs(cmd_runs),
    .busy(busy), .done(done), .timeout_err(timeout_err), .accel_start(accel_start),
    .accel_finish(accel_finish), .accel_return_val(accel_return_val),
    .last_return_val(last_return_val), .last_cycles(last_cycles),
    .total_cycles(total_cycles), .runs_done(runs_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          starts;
    int          rd;
    logic [31:0] tot;
    logic [31:0] lc;
    logic [31:0] lr;
    logic        err;
    int          done_cyc;
  } exp_t;

  exp_t        sb_q[$];
  int          pend_lat[$], pend_st[$];
  bit          pend_sp[$];
  logic [31:0] pend_ret[$];
  int          drv_lat[$], drv_st[$];
  bit          drv_sp[$];
  logic [31:0] drv_ret[$];

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          last_fin = -100;
  int          mon_starts = 0;
  logic [31:0] m_lc = 32'd0;
  logic [31:0] m_lr = 32'd0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Cycle counter; also records the last cycle in which accel_finish was high.
  always @(posedge clk) begin
    if (accel_finish) last_fin = cyc;
    cyc = cyc + 1;
  end

  // Accelerator model: reacts to each start with the next planned behaviour.
  initial begin
    int l;
    int s;
    int k;
    bit p;
    logic [31:0] r;
    accel_finish = 1'b0;
    accel_return_val = 32'd0;
    forever begin
      @(negedge clk);
      accel_return_val = $urandom;
      if (!reset && accel_start && drv_lat.size() > 0) begin
        l = drv_lat.pop_front();
        s = drv_st.pop_front();
        p = drv_sp.pop_front();
        r = drv_ret.pop_front();
        k = 0;
        if (p) begin
          // Spurious finish during the start cycle.
          accel_finish = 1'b1;
          @(negedge clk);
          accel_finish = 1'b0;
          k = 1;
        end
        if (l <= TO) begin
          repeat (l - k) @(negedge clk);
          accel_finish = 1'b1;
          accel_return_val = r;
          repeat (s) @(negedge clk);
          accel_finish = 1'b0;
          accel_return_val = $urandom;
        end
      end
    end
  end

  // Monitor: start spacing within a batch and batch results at each done.
  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      mon_starts = 0;
    end else begin
      if (accel_start) begin
        if (mon_starts > 0) chk("start_gap_cycle", 32'(cyc), 32'(last_fin + GAP + 1));
        mon_starts = mon_starts + 1;
      end
      if (done) begin
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done actual=1 required=0 (cycle %0d)", cyc);
        end else begin
          e = sb_q.pop_front();
          $display("batch done cycle=%0d starts=%0d runs_done=%0d total=%0d last_cycles=%0d err=%0d",
                   cyc, mon_starts, runs_done, total_cycles, last_cycles, timeout_err);
          chk("done_cycle", 32'(cyc), 32'(e.done_cyc));
          chk("start_count", 32'(mon_starts), 32'(e.starts));
          chk("runs_done", 32'(runs_done), 32'(e.rd));
          chk("total_cycles", total_cycles, e.tot);
          chk("last_cycles", last_cycles, e.lc);
          chk("last_return_val", last_return_val, e.lr);
          chk("timeout_err", 32'(timeout_err), 32'(e.err));
          chk("busy_at_done", 32'(busy), 32'd0);
        end
        mon_starts = 0;
      end
    end
  end

  task automatic add_run(input int lat, input int st, input bit sp, input logic [31:0] ret);
    pend_lat.push_back(lat);
    pend_st.push_back(st);
    pend_sp.push_back(sp);
    pend_ret.push_back(ret);
  endtask

  // Issue the pending plan as one batch; call at a falling edge with the DUT idle.
  task automatic run_batch();
    exp_t e;
    int n;
    int g;
    int t;
    longint unsigned tot;
    bit got;
    n = pend_lat.size();
    g = cyc;
    t = g + 1;
    tot = 0;
    e.starts = 0;
    e.rd = 0;
    e.err = 1'b0;
    e.done_cyc = g + 1;
    for (int i = 0; i < n; i++) begin
      e.starts++;
      drv_lat.push_back(pend_lat[i]);
      drv_st.push_back(pend_st[i]);
      drv_sp.push_back(pend_sp[i]);
      drv_ret.push_back(pend_ret[i]);
      if (pend_lat[i] > TO) begin
        e.err = 1'b1;
        e.done_cyc = t + TO + 1;
        break;
      end
      e.rd++;
      tot = tot + longint'(pend_lat[i]);
      if (tot > 64'hFFFF_FFFF) tot = 64'hFFFF_FFFF;
      m_lc = 32'(pend_lat[i]);
      m_lr = pend_ret[i];
      if (i == n - 1) e.done_cyc = t + pend_lat[i] + 1;
      else t = t + pend_lat[i] + pend_st[i] + GAP;
    end
    e.tot = tot[31:0];
    e.lc = m_lc;
    e.lr = m_lr;
    sb_q.push_back(e);
    pend_lat.delete();
    pend_st.delete();
    pend_sp.delete();
    pend_ret.delete();
    $display("issue batch runs=%0d cycle=%0d expect_done=%0d", n, g, e.done_cyc);
    cmd_go = 1'b1;
    cmd_runs = 8'(n);
    @(negedge clk);
    cmd_go = 1'b0;
    chk("busy_after_go", 32'(busy), (n != 0) ? 32'd1 : 32'd0);
    chk("timeout_err_cleared", 32'(timeout_err), 32'd0);
    got = 1'b0;
    for (int k = 0; k < 3000; k++) begin
      if (done) begin
        got = 1'b1;
        break;
      end
      // Host noise while busy; must be ignored.
      if ($urandom_range(0, 3) == 0) begin
        cmd_go = 1'b1;
        cmd_runs = 8'($urandom);
      end else begin
        cmd_go = 1'b0;
      end
      @(negedge clk);
    end
    cmd_go = 1'b0;
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL done_wait actual=no_done required=done (cycle %0d)", cyc);
    end
    repeat (5) @(negedge clk);
  endtask

  initial begin
    int n;
    int l;
    reset = 1'b1;
    cmd_go = 1'b0;
    cmd_runs = 8'd0;
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_start", 32'(accel_start), 32'd0);
    chk("rst_terr", 32'(timeout_err), 32'd0);
    chk("rst_runs_done", 32'(runs_done), 32'd0);
    chk("rst_total", total_cycles, 32'd0);
    chk("rst_last_cycles", last_cycles, 32'd0);
    chk("rst_last_ret", last_return_val, 32'd0);
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // Single run, latency 5, result 42.
    add_run(5, 1, 1'b0, 32'd42);
    run_batch();
    // Three runs, latencies 4, 7, 1.
    add_run(4, 1, 1'b0, $urandom);
    add_run(7, 1, 1'b0, $urandom);
    add_run(1, 1, 1'b0, $urandom);
    run_batch();
    // Timeout; the following batch must clear the flag.
    add_run(100, 1, 1'b0, $urandom);
    run_batch();
    // Zero-run batch.
    run_batch();
    // Finish in START is ignored; timeout still counts.
    add_run(100, 1, 1'b1, $urandom);
    run_batch();
    // START-cycle finishes followed by real finishes.
    add_run(1, 1, 1'b1, $urandom);
    add_run(6, 1, 1'b1, $urandom);
    run_batch();
    // Latency exactly at the timeout limit still completes.
    add_run(16, 2, 1'b0, $urandom);
    run_batch();
    // Stretched finish in run 1 of 2.
    add_run(3, 3, 1'b0, $urandom);
    add_run(2, 1, 1'b0, $urandom);
    run_batch();

    // Randomized batches.
    for (int b = 0; b < 25; b++) begin
      n = $urandom_range(0, 4);
      for (int i = 0; i < n; i++) begin
        l = ($urandom_range(0, 9) == 0) ? 40 : $urandom_range(1, TO);
        add_run(l, $urandom_range(1, 3), ($urandom_range(0, 4) == 0), $urandom);
      end
      run_batch();
    end

    // Reset during run 2 of 4 (latency 3 each).
    for (int i = 0; i < 4; i++) begin
      drv_lat.push_back(3);
      drv_st.push_back(1);
      drv_sp.push_back(1'b0);
      drv_ret.push_back($urandom);
    end
    cmd_go = 1'b1;
    cmd_runs = 8'd4;
    @(negedge clk);
    cmd_go = 1'b0;
    repeat (7) @(negedge clk);
    chk("pre_reset_runs_done", 32'(runs_done), 32'd1);
    chk("pre_reset_busy", 32'(busy), 32'd1);
    #2 reset = 1'b1;
    #1;
    $display("mid-batch reset at cycle %0d", cyc);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_done", 32'(done), 32'd0);
    chk("mid_rst_start", 32'(accel_start), 32'd0);
    chk("mid_rst_runs_done", 32'(runs_done), 32'd0);
    chk("mid_rst_total", total_cycles, 32'd0);
    chk("mid_rst_last_cycles", last_cycles, 32'd0);
    chk("mid_rst_last_ret", last_return_val, 32'd0);
    drv_lat.delete();
    drv_st.delete();
    drv_sp.delete();
    drv_ret.delete();
    m_lc = 32'd0;
    m_lr = 32'd0;
    repeat (6) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("post_rst_start", 32'(accel_start), 32'd0);
    add_run(4, 1, 1'b0, $urandom);
    run_batch();

    chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

endmodule
